// File: rtl/gigatron_video_capture.sv
// Captures the Gigatron OUT-port video stream into a 160x120 6-bit framebuffer,
// tracking sync timing with a small state machine and a lock/timeout monitor.
module gigatron_video_capture #(
    parameter int H_BACK   = 12,
    parameter int H_PIXELS = 160,
    parameter int V_BACK   = 33,
    parameter int V_LINES  = 480,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [7:0]  out_i,
    output logic [14:0] fb_addr,
    output logic [5:0]  fb_data,
    output logic        fb_we,
    output logic        frame_done,
    output logic        locked,
    output logic [8:0]  line,
    output logic [2:0]  o_dbg_state
);

    localparam int VC_W = (V_BACK > 1) ? $clog2(V_BACK) : 1;
    localparam int HC_W = (H_BACK > 1) ? $clog2(H_BACK) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_WAIT_VS = 3'd0,
        S_VBLANK  = 3'd1,
        S_HBACK   = 3'd2,
        S_ACTIVE  = 3'd3,
        S_HIDLE   = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_prev, w_prev_nxt;
    logic [VC_W-1:0]   r_vcnt, w_vcnt_nxt;
    logic [HC_W-1:0]   r_hcnt, w_hcnt_nxt;
    logic [7:0]        r_col, w_col_nxt;
    logic [8:0]        r_line, w_line_nxt;
    logic [TO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [14:0]       r_fb_addr, w_fb_addr_nxt;
    logic [5:0]        r_fb_data, w_fb_data_nxt;
    logic              r_fb_we, w_fb_we_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_locked, w_locked_nxt;

    logic w_vs_fall, w_vs_rise, w_hs_fall, w_hs_rise;

    // Edges are only meaningful on ce samples; r_prev holds the previous ce sample.
    assign w_vs_fall = ce &  r_prev[1] & ~out_i[7];
    assign w_vs_rise = ce & ~r_prev[1] &  out_i[7];
    assign w_hs_fall = ce &  r_prev[0] & ~out_i[6];
    assign w_hs_rise = ce & ~r_prev[0] &  out_i[6];

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_vcnt_nxt       = r_vcnt;
        w_hcnt_nxt       = r_hcnt;
        w_col_nxt        = r_col;
        w_line_nxt       = r_line;
        w_tmo_nxt        = r_tmo;
        w_fb_addr_nxt    = r_fb_addr;
        w_fb_data_nxt    = r_fb_data;
        w_fb_we_nxt      = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_locked_nxt     = r_locked;

        if (ce) begin
            w_prev_nxt = out_i[7:6];

            if (w_hs_fall) begin
                w_tmo_nxt = '0;
            end else if (r_tmo != TO_W'(TIMEOUT)) begin
                w_tmo_nxt = r_tmo + TO_W'(1);
            end
            if (w_tmo_nxt == TO_W'(TIMEOUT)) begin
                w_locked_nxt = 1'b0;
            end

            // A vsync fall outranks everything, including a coincident hsync rise.
            if (w_vs_fall && (r_state != S_WAIT_VS)) begin
                w_state_nxt  = S_WAIT_VS;
                w_locked_nxt = 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_VS: begin
                        if (w_vs_rise) begin
                            w_state_nxt = S_VBLANK;
                            w_vcnt_nxt  = '0;
                            w_line_nxt  = '0;
                        end
                    end
                    S_VBLANK: begin
                        if (w_hs_rise) begin
                            if (r_vcnt == VC_W'(V_BACK - 1)) begin
                                w_state_nxt = S_HBACK;
                                w_line_nxt  = '0;
                                w_hcnt_nxt  = '0;
                            end else begin
                                w_vcnt_nxt = r_vcnt + VC_W'(1);
                            end
                        end
                    end
                    S_HBACK: begin
                        // H_BACK samples are spent here after the hsync rise sample.
                        if (r_hcnt == HC_W'(H_BACK - 1)) begin
                            w_state_nxt = S_ACTIVE;
                            w_col_nxt   = '0;
                        end else begin
                            w_hcnt_nxt = r_hcnt + HC_W'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (w_hs_fall) begin
                            w_state_nxt = S_HIDLE;
                        end else begin
                            w_fb_data_nxt = out_i[5:0];
                            w_fb_addr_nxt = {r_line[8:2], r_col};
                            w_fb_we_nxt   = (r_line[1:0] == 2'b00);
                            if (r_col == 8'(H_PIXELS - 1)) begin
                                w_state_nxt = S_HIDLE;
                            end else begin
                                w_col_nxt = r_col + 8'd1;
                            end
                        end
                    end
                    S_HIDLE: begin
                        if (w_hs_rise) begin
                            if (r_line == 9'(V_LINES - 1)) begin
                                w_state_nxt      = S_WAIT_VS;
                                w_line_nxt       = '0;
                                w_frame_done_nxt = 1'b1;
                                w_locked_nxt     = 1'b1;
                            end else begin
                                w_state_nxt = S_HBACK;
                                w_line_nxt  = r_line + 9'd1;
                                w_hcnt_nxt  = '0;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = S_WAIT_VS;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_VS;
            r_prev       <= 2'b11;
            r_vcnt       <= '0;
            r_hcnt       <= '0;
            r_col        <= '0;
            r_line       <= '0;
            r_tmo        <= '0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_fb_we      <= 1'b0;
            r_frame_done <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_vcnt       <= w_vcnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_col        <= w_col_nxt;
            r_line       <= w_line_nxt;
            r_tmo        <= w_tmo_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_data    <= w_fb_data_nxt;
            r_fb_we      <= w_fb_we_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_locked     <= w_locked_nxt;
        end
    end

    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign fb_we       = r_fb_we;
    assign frame_done  = r_frame_done;
    assign locked      = r_locked;
    assign line        = r_line;
    assign o_dbg_state = r_state;

endmodule

// File: doc/gigatron_video_capture.md
GIGATRON_VIDEO_CAPTURE -- requirements
Module: gigatron_video_capture

Interface
REQ-001 Parameters (name, default, meaning): H_BACK, 12, ce cycles from hsync rising edge to first pixel; H_PIXELS, 160, pixels per line; V_BACK, 33, hsync rising edges from vsync rising edge to first visible line; V_LINES, 480, visible lines per frame; TIMEOUT, 1023, ce cycles without an hsync falling edge before lock is lost.
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ce  in  1  CPU cycle strobe; out_i is sampled only when ce=1
- out_i  in  8  CPU OUT port: [7] vsync (active low), [6] hsync (active low), [5:0] pixel BBGGRR
- fb_addr  out  15  framebuffer address {row[6:0], col[7:0]}
- fb_data  out  6  pixel to write
- fb_we  out  1  framebuffer write strobe, one clock wide
- frame_done  out  1  one-clock pulse at the end of a complete frame
- locked  out  1  valid video timing detected
- line  out  9  current visible line index

Function
REQ-003 All sampling, edge detection and counting SHALL advance only on clocks with ce=1; with ce=0 all state SHALL hold and fb_we/frame_done SHALL be 0.
REQ-004 Edge detection SHALL compare out_i[7:6] with a registered copy of the previous ce sample; fall = prev 1, now 0; rise = prev 0, now 1.
REQ-005 States SHALL be WAIT_VS, VBLANK, HBACK, ACTIVE and HIDLE.
REQ-006 WAIT_VS: on vsync rise -> VBLANK, with the vertical counter cleared.
REQ-007 VBLANK: count hsync rises; on the V_BACK-th rise -> HBACK with line=0 and the horizontal counter cleared.
REQ-008 HBACK: count ce cycles; after H_BACK cycles -> ACTIVE with col=0.
REQ-009 ACTIVE: each ce cycle SHALL capture out_i[5:0] to fb_data with fb_addr={line[8:2], col}. fb_we=1 is required only when line[1:0]==0, giving a 160x120 framebuffer. col SHALL increment; after col=H_PIXELS-1 -> HIDLE.
REQ-010 HIDLE: on hsync rise, line SHALL increment. If the new line is < V_LINES -> HBACK; else -> WAIT_VS.
REQ-011 Write latency SHALL be one clock: a pixel sampled on ce edge N appears with fb_we=1 on the clock after N.
REQ-012 If hsync falls during ACTIVE before H_PIXELS pixels, the line SHALL be aborted -> HIDLE. Pixels already written SHALL remain, and no further writes SHALL occur for that line.
REQ-013 A vsync fall in any state other than WAIT_VS SHALL force -> WAIT_VS (frame aborted).
REQ-014 frame_done SHALL pulse when the V_LINES-th line completes (HIDLE -> WAIT_VS).
REQ-015 locked SHALL set on frame_done.
REQ-016 locked SHALL clear on a frame abort (REQ-013) or when TIMEOUT ce cycles pass without an hsync fall.
REQ-017 The timeout counter SHALL saturate at TIMEOUT and reset on every hsync fall.
REQ-018 Simultaneous hsync rise and vsync fall on the same sample: vsync SHALL take priority.
REQ-019 col SHALL never exceed H_PIXELS-1, and line SHALL never exceed V_LINES-1 while in ACTIVE; fb_addr SHALL not wrap.

Reset
REQ-020 On rst_n=0 at a clock edge, the block SHALL enter WAIT_VS and take these values: fb_addr=0, fb_data=0, fb_we=0, frame_done=0, locked=0, line=0, all counters 0, prev sync sample = 2'b11. Reset mid-line SHALL discard the frame without further writes.

Verification
REQ-021 Ideal Gigatron timing stream, ce every 4th clock, 2 frames -> exactly 160x120 fb_we pulses per frame; frame_done pulses once per frame; locked=1 after the first frame.
REQ-022 Pixel ramp col value = col[5:0] on line 4 -> fb_addr 0x0100..0x019F with fb_data 0..63 repeating; no writes on lines 5-7.
REQ-023 hsync fall after 100 pixels on line 0 -> 100 writes, addresses 0x0000..0x0063, then none until line 4.
REQ-024 vsync fall at line 200 -> no frame_done; locked 1->0; the next full frame sets locked again.
REQ-025 Hold out_i=8'hFF for 1100 ce cycles while locked -> locked=0 at ce cycle 1023.
REQ-026 Assert rst_n=0 for one clock in mid-ACTIVE -> next clock fb_we=0, locked=0; no writes until V_BACK hsyncs after the next vsync rise.
